// File: rtl/nios2_gpio_pkg.sv
// Shared constants for the Nios II GPIO interrupt PIO: register word
// addresses and the per-channel edge-mode encodings.
package nios2_gpio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DEB  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_MODE = 3'd4;

    typedef enum logic [1:0] {
        EM_RISE = 2'b00,
        EM_FALL = 2'b01,
        EM_BOTH = 2'b10,
        EM_OFF  = 2'b11
    } edge_mode_e;

endpackage

// File: rtl/nios2_gpio_debounce.sv
// One input channel: synchroniser chain, saturating debounce counter,
// debounced (stable) level and its one-cycle-delayed copy for edge detect.
module nios2_gpio_debounce #(
    parameter int         SYNC_STAGES = 2,
    parameter int         DEB_W       = 16,
    parameter logic       IDLE_LEVEL  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic [DEB_W-1:0] deb_limit,
    output logic             stable,
    output logic             prev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_W-1:0]       cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
        end
    end

    // Commit the synchronised level once it has differed for deb_limit+1 cycles.
    // Using >= lets a lowered limit commit immediately and keeps cnt from wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= IDLE_LEVEL;
            prev   <= IDLE_LEVEL;
        end else begin
            prev <= stable;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt >= deb_limit) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios2_gpio_irq.sv
// Nios II GPIO interrupt PIO: WIDTH debounced inputs, selectable edge type,
// write-1-to-clear edge capture, masked level IRQ and an Avalon-MM register file.
module nios2_gpio_irq
    import nios2_gpio_pkg::*;
#(
    parameter int               WIDTH       = 3,
    parameter int               SYNC_STAGES = 2,
    parameter int               DEB_W       = 16,
    parameter logic [DEB_W-1:0] DEB_DEFAULT = 16'd50000,
    parameter logic             IDLE_LEVEL  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [DEB_W-1:0]   deb_limit;
    logic [WIDTH-1:0]   irq_mask;
    logic [WIDTH-1:0]   edge_capture;
    logic [2*WIDTH-1:0] edge_mode;
    logic [WIDTH-1:0]   stable;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   evt;
    logic [WIDTH-1:0]   clr;
    logic [31:0]        rd_next;
    logic               wr;
    logic               unused_wd;

    assign wr        = chipselect && !write_n;
    assign unused_wd = ^writedata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        nios2_gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W),
            .IDLE_LEVEL  (IDLE_LEVEL)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .in_bit    (in_port[g]),
            .deb_limit (deb_limit),
            .stable    (stable[g]),
            .prev      (prev[g])
        );
    end

    // Per-channel edge event selected by the channel's 2-bit mode field.
    always_comb begin
        evt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case (edge_mode_e'(edge_mode[2*i +: 2]))
                EM_RISE: evt[i] = stable[i] & ~prev[i];
                EM_FALL: evt[i] = ~stable[i] & prev[i];
                EM_BOTH: evt[i] = stable[i] ^ prev[i];
                default: evt[i] = 1'b0;
            endcase
        end
    end

    // Write-1-to-clear mask for the edge capture register.
    always_comb begin
        clr = '0;
        if (wr && address == ADDR_EDGE) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    // Read mux; unused bits and unmapped addresses return zero.
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next[WIDTH-1:0]   = stable;
            ADDR_DEB:  rd_next[DEB_W-1:0]   = deb_limit;
            ADDR_MASK: rd_next[WIDTH-1:0]   = irq_mask;
            ADDR_EDGE: rd_next[WIDTH-1:0]   = edge_capture;
            ADDR_MODE: rd_next[2*WIDTH-1:0] = edge_mode;
            default:   rd_next = '0;
        endcase
    end

    // Control registers, edge capture (set beats clear) and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_limit    <= DEB_DEFAULT;
            irq_mask     <= '0;
            edge_mode    <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            readdata     <= rd_next;
            edge_capture <= (edge_capture & ~clr) | evt;
            if (wr) begin
                case (address)
                    ADDR_DEB:  deb_limit <= writedata[DEB_W-1:0];
                    ADDR_MASK: irq_mask  <= writedata[WIDTH-1:0];
                    ADDR_MODE: edge_mode <= writedata[2*WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
